mips_regfile_write_arbiter: RTL

//  Shares the single register-file write port between two writeback sources:
//   req0 = ALU writeback, req1 = memory/load writeback.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/mips_rr_arbiter2.sv | 44 ++++
 rtl/mips_regfile_write_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS writeback path.
// Register-file geometry, zero register and writeback source ids.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 3;
  localparam int CNT_W    = 2;
  localparam int NUM_REGS = 8;

  localparam logic [ADDR_W-1:0] ZERO_REG = 3'b000;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LD  = 1'b1
  } req_id_e;

  function automatic logic [1:0] id_onehot(req_id_e id);
    return (id == REQ_ALU) ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/mips_rr_arbiter2.sv
// Two-way round-robin grant with its priority pointer.
// The pointer flips to the other side after every grant.
module mips_rr_arbiter2
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_hold,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  req_id_e    r_ptr;
  logic [1:0] w_gnt;
  logic       w_both;

  assign w_both = i_req[0] & i_req[1];

  // grant decode: hold masks everything, contention goes to the pointer
  always_comb begin
    w_gnt = 2'b00;
    unique case (1'b1)
      i_hold:                       w_gnt = 2'b00;
      (!i_hold && w_both):          w_gnt = id_onehot(r_ptr);
      (!i_hold && i_req == 2'b01):  w_gnt = 2'b01;
      (!i_hold && i_req == 2'b10):  w_gnt = 2'b10;
      default:                      w_gnt = 2'b00;
    endcase
  end

  assign o_gnt = w_gnt;

  // pointer moves to the side that was not just served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= REQ_ALU;
    end else if (w_gnt[0]) begin
      r_ptr <= REQ_LD;
    end else if (w_gnt[1]) begin
      r_ptr <= REQ_ALU;
    end
  end

endmodule

// File: rtl/mips_regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback.
// Registered write outputs plus a per-register outstanding-write scoreboard.
module mips_regfile_write_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int CNT_W  = mips_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hold,
  input  logic                    req0_valid,
  input  logic [ADDR_W-1:0]       req0_reg,
  input  logic [DATA_W-1:0]       req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [ADDR_W-1:0]       req1_reg,
  input  logic [DATA_W-1:0]       req1_data,
  output logic                    req1_ready,
  input  logic                    rsv_valid,
  input  logic [ADDR_W-1:0]       rsv_reg,
  output logic                    rsv_ready,
  output logic [ADDR_W-1:0]       write_reg,
  output logic [DATA_W-1:0]       write_data,
  output logic                    signal_reg_write,
  output logic [(1<<ADDR_W)-1:0]  busy_mask,
  output logic                    err_underflow
);

  localparam int NREG = 1 << ADDR_W;

  logic [1:0]        w_gnt;
  logic              w_gnt_any;
  logic [ADDR_W-1:0] w_gnt_reg;
  logic [DATA_W-1:0] w_gnt_data;
  logic              w_gnt_live;
  logic              w_sat;
  logic              w_same;
  logic              w_rsv_acc;
  logic              w_uflow;
  logic [CNT_W-1:0]  w_cnt [NREG];

  logic [ADDR_W-1:0] r_wreg;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wen;
  logic              r_err;

  mips_rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_hold (hold),
    .i_req  ({req1_valid, req0_valid}),
    .o_gnt  (w_gnt)
  );

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign w_gnt_any  = |w_gnt;
  assign w_gnt_reg  = w_gnt[1] ? req1_reg  : req0_reg;
  assign w_gnt_data = w_gnt[1] ? req1_data : req0_data;

  // r0 grants are swallowed: no write, no scoreboard effect
  assign w_gnt_live = w_gnt_any && (w_gnt_reg != ZERO_REG);

  assign w_sat  = (w_cnt[rsv_reg] == {CNT_W{1'b1}});
  assign w_same = w_gnt_live && (w_gnt_reg == rsv_reg);

  assign rsv_ready = (rsv_reg == ZERO_REG) | ~w_sat | w_same;

  assign w_rsv_acc = rsv_valid && rsv_ready
                  && (rsv_reg != ZERO_REG);

  // a completion cancelled by a same-register reserve never underflows
  assign w_uflow = w_gnt_live
                && !(w_rsv_acc && (rsv_reg == w_gnt_reg))
                && (w_cnt[w_gnt_reg] == '0);

  // output register: held stable across the file's negedge write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wreg  <= '0;
      r_wdata <= '0;
      r_wen   <= 1'b0;
    end else begin
      r_wen <= w_gnt_live;
      if (w_gnt_live) begin
        r_wreg  <= w_gnt_reg;
        r_wdata <= w_gnt_data;
      end
    end
  end

  // sticky underflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_uflow) begin
      r_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_sb
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(g);

    logic             w_inc;
    logic             w_dec;
    logic [CNT_W-1:0] r_cnt;

    assign w_inc = w_rsv_acc && (rsv_reg == IDX);
    assign w_dec = w_gnt_live && (w_gnt_reg == IDX);

    // outstanding-write count; inc and dec together cancel
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_inc && !w_dec) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_dec && !w_inc && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end

    assign w_cnt[g]     = r_cnt;
    assign busy_mask[g] = (IDX != ZERO_REG) && (r_cnt != '0);
  end

  assign write_reg        = r_wreg;
  assign write_data       = r_wdata;
  assign signal_reg_write = r_wen;
  assign err_underflow    = r_err;

endmodule
